// File: rtl/vga_plot_engine.sv
// Plot-request FIFO feeding a registered VGA adapter write port, with a full-screen clear sweep.
// Define PLOT_CLIP_EN to drop popped requests that fall outside H_RES x V_RES.
module vga_plot_engine #(
    parameter int unsigned X_W      = 8,
    parameter int unsigned Y_W      = 7,
    parameter int unsigned COLOUR_W = 3,
    parameter int unsigned H_RES    = 160,
    parameter int unsigned V_RES    = 120,
    parameter int unsigned DEPTH    = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic [X_W-1:0]            in_x,
    input  logic [Y_W-1:0]            in_y,
    input  logic [COLOUR_W-1:0]       in_colour,
    output logic                      in_ready,
    input  logic                      clear_req,
    input  logic [COLOUR_W-1:0]       clear_colour,
    output logic                      clear_busy,
    output logic                      busy,
    output logic [$clog2(DEPTH):0]    level,
    output logic [X_W-1:0]            vga_x,
    output logic [Y_W-1:0]            vga_y,
    output logic [COLOUR_W-1:0]       vga_colour,
    output logic                      vga_write
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned EW = X_W + Y_W + COLOUR_W;
    localparam logic [X_W-1:0] XLast = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0] YLast = Y_W'(V_RES - 1);

    typedef enum logic [1:0] {StIdle, StDrain, StClear} state_e;

    state_e                state_q, state_d;
    logic [EW-1:0]         mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]         level_q, level_d;
    logic [X_W-1:0]        cx_q, cx_d;
    logic [Y_W-1:0]        cy_q, cy_d;
    logic [COLOUR_W-1:0]   clr_colour_q;
    logic                  clr_tail_q;
    logic [X_W-1:0]        vga_x_q, vga_x_d;
    logic [Y_W-1:0]        vga_y_q, vga_y_d;
    logic [COLOUR_W-1:0]   vga_colour_q, vga_colour_d;
    logic                  vga_write_q, vga_write_d;

    logic                  push, pop, pop_ok, start_clear, last_pixel;
    logic [X_W-1:0]        pop_x;
    logic [Y_W-1:0]        pop_y;
    logic [COLOUR_W-1:0]   pop_colour;

    assign in_ready   = (level_q != LW'(DEPTH));
    assign push       = in_valid && in_ready;
    assign pop        = (state_q == StDrain) && (level_q != '0);
    assign last_pixel = (cx_q == XLast) && (cy_q == YLast);
    assign {pop_x, pop_y, pop_colour} = mem_q[rd_ptr_q];

`ifdef PLOT_CLIP_EN
    assign pop_ok = (32'(pop_x) < H_RES) && (32'(pop_y) < V_RES);
`else
    assign pop_ok = 1'b1;
`endif

    always_comb begin
        level_d = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // clr_tail_q keeps clear_busy up through the cycle that shows the last sweep pixel
    always_comb begin
        state_d     = state_q;
        start_clear = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (clear_req && !clear_busy) begin
                    state_d     = StClear;
                    start_clear = 1'b1;
                end else if (level_q != '0) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (clear_req && !clear_busy) begin
                    state_d     = StClear;
                    start_clear = 1'b1;
                end else if (level_d == '0) begin
                    state_d = StIdle;
                end
            end
            StClear: begin
                if (last_pixel) begin
                    state_d = (level_d != '0) ? StDrain : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cx_d = cx_q;
        cy_d = cy_q;
        if (start_clear) begin
            cx_d = '0;
            cy_d = '0;
        end else if (state_q == StClear) begin
            if (cx_q == XLast) begin
                cx_d = '0;
                cy_d = (cy_q == YLast) ? '0 : cy_q + Y_W'(1);
            end else begin
                cx_d = cx_q + X_W'(1);
            end
        end
    end

    always_comb begin
        vga_write_d  = 1'b0;
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_colour_d = vga_colour_q;
        if (pop) begin
            if (pop_ok) begin
                vga_write_d  = 1'b1;
                vga_x_d      = pop_x;
                vga_y_d      = pop_y;
                vga_colour_d = pop_colour;
            end
        end else if (state_q == StClear) begin
            vga_write_d  = 1'b1;
            vga_x_d      = cx_q;
            vga_y_d      = cy_q;
            vga_colour_d = clr_colour_q;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_x, in_y, in_colour};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            cx_q         <= '0;
            cy_q         <= '0;
            clr_colour_q <= '0;
            clr_tail_q   <= 1'b0;
            vga_write_q  <= 1'b0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
        end else begin
            state_q      <= state_d;
            level_q      <= level_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            clr_tail_q   <= (state_q == StClear) && last_pixel;
            vga_write_q  <= vga_write_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (start_clear) begin
                clr_colour_q <= clear_colour;
            end
        end
    end

    assign clear_busy = (state_q == StClear) || clr_tail_q;
    assign busy       = (level_q != '0) || clear_busy || (state_q != StIdle) || vga_write_q;
    assign level      = level_q;
    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_colour_q;
    assign vga_write  = vga_write_q;

endmodule

// File: tb/tb_vga_plot_engine.sv
// Self-checking bench for vga_plot_engine: vector table, clear/reset sequences, random traffic.
module tb_vga_plot_engine;

    localparam int H = 160;
    localparam int V = 120;
    localparam int D = 8;
`ifdef PLOT_CLIP_EN
    localparam bit CLIP = 1'b1;
`else
    localparam bit CLIP = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_x;
    logic [6:0] in_y;
    logic [2:0] in_colour;
    logic       in_ready;
    logic       clear_req;
    logic [2:0] clear_colour;
    logic       clear_busy;
    logic       busy;
    logic [3:0] level;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_write;

    vga_plot_engine #(
        .X_W(8), .Y_W(7), .COLOUR_W(3), .H_RES(H), .V_RES(V), .DEPTH(D)
    ) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_x(in_x), .in_y(in_y), .in_colour(in_colour),
        .in_ready(in_ready),
        .clear_req(clear_req), .clear_colour(clear_colour), .clear_busy(clear_busy),
        .busy(busy), .level(level),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_write(vga_write)
    );

    always #5 clock = ~clock;

    typedef struct { int x; int y; int c; } pix_t;
    typedef struct { int x; int y; int c; bit wr; } vec_t;

    pix_t obs[$];
    pix_t expq[$];
    int   tests = 0;
    int   fails = 0;

    always @(negedge clock) begin
        pix_t p;
        if (vga_write === 1'b1) begin
            p.x = int'(vga_x);
            p.y = int'(vga_y);
            p.c = int'(vga_colour);
            obs.push_back(p);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_pix(input string name, input int idx, input int x, input int y,
                             input int c);
        tests++;
        if (idx >= obs.size()) begin
            fails++;
            $display("FAIL %s: no write at index %0d, expected (%0d,%0d,%0d)", name, idx, x, y, c);
        end else if (obs[idx].x != x || obs[idx].y != y || obs[idx].c != c) begin
            fails++;
            $display("FAIL %s: got (%0d,%0d,%0d) at index %0d, expected (%0d,%0d,%0d)", name,
                     obs[idx].x, obs[idx].y, obs[idx].c, idx, x, y, c);
        end
    endtask

    // Whole raster sweep counts as a single comparison; reports the first bad pixel.
    task automatic check_sweep(input string name, input int start, input int colour);
        bit bad = 1'b0;
        tests++;
        for (int i = 0; i < H * V && !bad; i++) begin
            int idx = start + i;
            if (idx >= obs.size()) begin
                bad = 1'b1;
                $display("FAIL %s: sweep ended after %0d writes, expected %0d", name, i, H * V);
            end else if (obs[idx].x != i % H || obs[idx].y != i / H || obs[idx].c != colour) begin
                bad = 1'b1;
                $display("FAIL %s: pixel %0d got (%0d,%0d,%0d), expected (%0d,%0d,%0d)", name,
                         i, obs[idx].x, obs[idx].y, obs[idx].c, i % H, i / H, colour);
            end
        end
        if (bad) fails++;
    endtask

    task automatic wait_idle(input string name, input int bound);
        int n = 0;
        while (busy && n < bound) begin
            tick();
            n++;
        end
        check(name, int'(busy), 0);
    endtask

    function automatic bit in_range(input int x, input int y);
        return (x < H) && (y < V);
    endfunction

    task automatic push_one(input int x, input int y, input int c);
        in_valid  = 1'b1;
        in_x      = 8'(x);
        in_y      = 7'(y);
        in_colour = 3'(c);
        tick();
        in_valid  = 1'b0;
    endtask

    initial begin
        vec_t vecs[7];
        int   n0, n, acc, wr;

        vecs[0] = '{5, 7, 3, 1'b1};
        vecs[1] = '{0, 0, 0, 1'b1};
        vecs[2] = '{159, 119, 7, 1'b1};
        vecs[3] = '{160, 0, 1, 1'b0};
        vecs[4] = '{10, 127, 5, 1'b0};
        vecs[5] = '{255, 127, 6, 1'b0};
        vecs[6] = '{80, 60, 4, 1'b1};
        for (int i = 0; i < 7; i++) begin
            vecs[i].wr = !CLIP || in_range(vecs[i].x, vecs[i].y);
        end

        reset = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0; in_colour = '0;
        clear_req = 1'b0; clear_colour = '0;
        #1 reset = 1'b1;
        #1;
        check("rst_level", int'(level), 0);
        check("rst_vga_write", int'(vga_write), 0);
        check("rst_vga_xyc", int'({vga_x, vga_y, vga_colour}), 0);
        check("rst_clear_busy", int'(clear_busy), 0);
        check("rst_busy", int'(busy), 0);
        repeat (2) @(posedge clock);
        @(negedge clock) reset = 1'b0;
        #1 check("ready_after_reset", int'(in_ready), 1);
        tick();

        // Single request into an empty, idle engine: write appears two edges after the push.
        for (int i = 0; i < 7; i++) begin
            push_one(vecs[i].x, vecs[i].y, vecs[i].c);
            check("vec_level1", int'(level), 1);
            check("vec_no_write_t1", int'(vga_write), 0);
            tick();
            check("vec_no_write_t2", int'(vga_write), 0);
            tick();
            check("vec_write_t3", int'(vga_write), int'(vecs[i].wr));
            if (vecs[i].wr) begin
                check("vec_x", int'(vga_x), vecs[i].x % 256);
                check("vec_y", int'(vga_y), vecs[i].y % 128);
                check("vec_c", int'(vga_colour), vecs[i].c);
            end
            tick();
            check("vec_single_cycle", int'(vga_write), 0);
            wait_idle("vec_idle", 20);
        end

        // Out-of-range then in-range request back to back.
        obs.delete();
        push_one(160, 0, 1);
        push_one(10, 10, 2);
        wait_idle("clip_idle", 20);
        check("clip_count", obs.size(), CLIP ? 1 : 2);
        if (CLIP) begin
            check_pix("clip_kept", 0, 10, 10, 2);
        end else begin
            check_pix("noclip_first", 0, 160, 0, 1);
            check_pix("noclip_second", 1, 10, 10, 2);
        end

        // Clear colour 4 while flooding the FIFO: fills to DEPTH, then drains in order.
        obs.delete();
        clear_req = 1'b1; clear_colour = 3'd4;
        tick();
        clear_req = 1'b0; clear_colour = 3'd1;
        check("clear_busy_start", int'(clear_busy), 1);
        for (int k = 0; k < 12; k++) begin
            in_valid = 1'b1; in_x = 8'(k + 20); in_y = 7'(k + 1); in_colour = 3'(k % 8);
            check("ready_while_filling", int'(in_ready), int'(k < D));
            tick();
        end
        in_valid = 1'b0;
        check("full_level", int'(level), D);
        check("full_ready", int'(in_ready), 0);
        wait_idle("clearA_idle", 25000);
        check_sweep("sweep_colour4", 0, 4);
        for (int j = 0; j < D; j++) begin
            check_pix("fifo_order", H * V + j, j + 20, j + 1, j % 8);
        end
        check("clearA_total", obs.size(), H * V + D);
        check("clearA_busy_low", int'(clear_busy), 0);

        // Clear requested in DRAIN with three queued entries.
        obs.delete();
        clear_req = 1'b1; clear_colour = 3'd2;
        tick();
        clear_req = 1'b0;
        for (int k = 0; k < 4; k++) push_one(30 + k, 40 + k, k + 1);
        n = 0;
        while (clear_busy && n < 25000) begin
            tick();
            n++;
        end
        check("clearB_busy_drop", int'(clear_busy), 0);
        check("clearB_level3", int'(level), 3);
        clear_req = 1'b1; clear_colour = 3'd6;
        tick();
        clear_req = 1'b0;
        wait_idle("clearB_idle", 25000);
        check_sweep("sweep_colour2", 0, 2);
        check_pix("drain_e0", H * V, 30, 40, 1);
        check_pix("drain_e1_completes", H * V + 1, 31, 41, 2);
        check_sweep("sweep_colour6", H * V + 2, 6);
        check_pix("drain_e2", 2 * H * V + 2, 32, 42, 3);
        check_pix("drain_e3", 2 * H * V + 3, 33, 43, 4);
        check("clearB_total", obs.size(), 2 * H * V + 4);

        // Reset in the middle of a sweep with entries queued.
        obs.delete();
        clear_req = 1'b1; clear_colour = 3'd5;
        tick();
        clear_req = 1'b0;
        for (int k = 0; k < 3; k++) push_one(1 + k, 2, 3);
        n = 0;
        while (obs.size() < 500 && n < 1000) begin
            tick();
            n++;
        end
        check("pre_reset_writes", obs.size(), 500);
        #2 reset = 1'b1;
        #1;
        check("midrst_vga_write", int'(vga_write), 0);
        check("midrst_level", int'(level), 0);
        check("midrst_clear_busy", int'(clear_busy), 0);
        check("midrst_busy", int'(busy), 0);
        @(negedge clock) reset = 1'b0;
        #1 check("midrst_ready", int'(in_ready), 1);
        n0 = obs.size();
        repeat (50) tick();
        check("no_writes_after_reset", obs.size(), n0);
        check("idle_after_reset", int'(busy), 0);

        // Random in-range traffic against a queue model.
        obs.delete();
        expq.delete();
        acc = 0;
        wr = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            pix_t p;
            in_valid = ($urandom_range(0, 3) != 0);
            p.x = int'($urandom_range(0, H - 1));
            p.y = int'($urandom_range(0, V - 1));
            p.c = int'($urandom_range(0, 7));
            in_x = 8'(p.x); in_y = 7'(p.y); in_colour = 3'(p.c);
            if (in_valid && (acc - wr) != D) begin
                acc++;
                expq.push_back(p);
            end
            tick();
            if (vga_write) wr++;
            check("rand_level", int'(level), acc - wr);
            check("rand_ready", int'(in_ready), int'((acc - wr) != D));
        end
        in_valid = 1'b0;
        wait_idle("rand_idle", 50);
        check("rand_count", obs.size(), expq.size());
        for (int i = 0; i < expq.size(); i++) begin
            check_pix("rand_order", i, expq[i].x, expq[i].y, expq[i].c);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
